mm2s_readback: RTL and testbench

Read-back checker for the DataMover memory path. It issues MM2S commands over a block of DDR3 that the S2MM path has already filled with an incrementing 64-bit count. It consumes the returned stream, compares every beat against the expected count, and checks each status word. It sits between `mover_control` and the `system` block diagram, on the MM2S command, status and data ports, and reports pass/fail plus error counts for ILA capture.

---
 rtl/dm_pkg.sv | 49 ++++
 rtl/mm2s_readback.sv | 146 ++++++++++++++
 tb/tb_mm2s_readback.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared DataMover definitions: command/status field layout, the read-back
// FSM state type and a command-word builder that the S2MM side can reuse.
package dm_pkg;

    localparam int unsigned CMD_W    = 72;
    localparam int unsigned BTT_LSB  = 0;
    localparam int unsigned BTT_W    = 23;
    localparam int unsigned TYPE_BIT = 23;
    localparam int unsigned DSA_LSB  = 24;
    localparam int unsigned DSA_W    = 6;
    localparam int unsigned EOF_BIT  = 30;
    localparam int unsigned DRR_BIT  = 31;
    localparam int unsigned ADDR_LSB = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned TAG_LSB  = 64;
    localparam int unsigned TAG_W    = 4;

    localparam int unsigned STS_OKAY    = 7;
    localparam int unsigned STS_SLVERR  = 6;
    localparam int unsigned STS_DECERR  = 5;
    localparam int unsigned STS_INTERR  = 4;
    localparam int unsigned STS_TAG_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_XFER,
        ST_STS,
        ST_DONE
    } rb_state_t;

    // INCR transfer, no DSA, no DRE realignment; reserved top nibble is zero.
    function automatic logic [CMD_W-1:0] dm_cmd(
        input logic [ADDR_W-1:0] addr,
        input logic [BTT_W-1:0]  btt,
        input logic [TAG_W-1:0]  tag,
        input logic              eof
    );
        logic [CMD_W-1:0] w;
        w                      = '0;
        w[BTT_LSB +: BTT_W]    = btt;
        w[TYPE_BIT]            = 1'b1;
        w[EOF_BIT]             = eof;
        w[ADDR_LSB +: ADDR_W]  = addr;
        w[TAG_LSB +: TAG_W]    = tag;
        return w;
    endfunction

endpackage

// File: rtl/mm2s_readback.sv
// Issues MM2S read commands over a pre-filled DDR3 block and checks the
// returned incrementing 64-bit count plus every status word.
module mm2s_readback
    import dm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [22:0] BTT       = 23'h00_1000,
    parameter int unsigned NUM_CMDS  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [63:0] seed,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] first_err_beat,
    output logic        len_err,
    output logic        sts_err,
    output logic        m_axis_mm2s_cmdsts_aresetn,
    output logic [71:0] S_AXIS_MM2S_CMD_tdata,
    output logic        S_AXIS_MM2S_CMD_tvalid,
    input  logic        S_AXIS_MM2S_CMD_tready,
    input  logic [7:0]  M_AXIS_MM2S_STS_tdata,
    input  logic        M_AXIS_MM2S_STS_tkeep,
    input  logic        M_AXIS_MM2S_STS_tlast,
    input  logic        M_AXIS_MM2S_STS_tvalid,
    output logic        M_AXIS_MM2S_STS_tready,
    input  logic [63:0] M_AXIS_MM2S_tdata,
    input  logic [7:0]  M_AXIS_MM2S_tkeep,
    input  logic        M_AXIS_MM2S_tlast,
    input  logic        M_AXIS_MM2S_tvalid,
    output logic        M_AXIS_MM2S_tready
);

    localparam logic [22:0] LAST_IDX = (BTT >> 3) - 23'd1;
    localparam logic [15:0] LAST_CMD = 16'(NUM_CMDS - 1);

    rb_state_t   state, next_state;
    logic [63:0] expected;
    logic [22:0] beat_cnt;
    logic [31:0] beat_idx;
    logic [15:0] cmd_idx;
    logic [31:0] addr;
    logic        pass_q;
    logic        beat, sts_hs, mism, sts_bad, pass_now;

    // Status framing carries no information for a single-byte status word.
    logic unused_sts;
    assign unused_sts = &{1'b0, M_AXIS_MM2S_STS_tkeep, M_AXIS_MM2S_STS_tlast};

    assign beat     = (state == ST_XFER) && M_AXIS_MM2S_tvalid;
    assign sts_hs   = (state == ST_STS) && M_AXIS_MM2S_STS_tvalid;
    assign mism     = (M_AXIS_MM2S_tdata != expected) || (M_AXIS_MM2S_tkeep != 8'hFF);
    assign sts_bad  = !M_AXIS_MM2S_STS_tdata[STS_OKAY]
                    || M_AXIS_MM2S_STS_tdata[STS_SLVERR]
                    || M_AXIS_MM2S_STS_tdata[STS_DECERR]
                    || M_AXIS_MM2S_STS_tdata[STS_INTERR]
                    || (M_AXIS_MM2S_STS_tdata[STS_TAG_LSB +: TAG_W] != cmd_idx[TAG_W-1:0]);
    assign pass_now = (err_count == '0) && !len_err && !sts_err;

    always_ff @(posedge clk) begin
        m_axis_mm2s_cmdsts_aresetn <= reset_n;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (start) next_state = ST_CMD;
            ST_CMD:  if (S_AXIS_MM2S_CMD_tready) next_state = ST_XFER;
            ST_XFER: if (beat && M_AXIS_MM2S_tlast) next_state = ST_STS;
            ST_STS:  if (sts_hs) next_state = (cmd_idx == LAST_CMD) ? ST_DONE : ST_CMD;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        S_AXIS_MM2S_CMD_tvalid = (state == ST_CMD);
        S_AXIS_MM2S_CMD_tdata  = dm_cmd(addr, BTT, cmd_idx[TAG_W-1:0], 1'b1);
        M_AXIS_MM2S_tready     = (state == ST_XFER);
        M_AXIS_MM2S_STS_tready = (state == ST_STS);
        busy                   = (state == ST_CMD) || (state == ST_XFER) || (state == ST_STS);
        done                   = (state == ST_DONE);
        pass                   = (state == ST_DONE) ? pass_now : pass_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            expected       <= '0;
            beat_cnt       <= '0;
            beat_idx       <= '0;
            cmd_idx        <= '0;
            addr           <= BASE_ADDR;
            err_count      <= '0;
            first_err_beat <= '1;
            len_err        <= 1'b0;
            sts_err        <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                expected       <= seed;
                beat_cnt       <= '0;
                beat_idx       <= '0;
                cmd_idx        <= '0;
                addr           <= BASE_ADDR;
                err_count      <= '0;
                first_err_beat <= '1;
                len_err        <= 1'b0;
                sts_err        <= 1'b0;
                pass_q         <= 1'b0;
            end
            if (beat) begin
                expected <= expected + 64'd1;
                beat_idx <= beat_idx + 32'd1;
                if (mism) begin
                    if (err_count != '1)      err_count      <= err_count + 16'd1;
                    if (first_err_beat == '1) first_err_beat <= beat_idx;
                end
                // A runaway stream is flagged on every overlong beat until tlast.
                if (M_AXIS_MM2S_tlast) begin
                    beat_cnt <= '0;
                    if (beat_cnt != LAST_IDX) len_err <= 1'b1;
                end else begin
                    if (beat_cnt != '1) beat_cnt <= beat_cnt + 23'd1;
                    if (beat_cnt >= LAST_IDX) len_err <= 1'b1;
                end
            end
            if (sts_hs) begin
                if (sts_bad) sts_err <= 1'b1;
                if (cmd_idx != LAST_CMD) begin
                    cmd_idx <= cmd_idx + 16'd1;
                    addr    <= addr + {9'd0, BTT};
                end
            end
            if (state == ST_DONE) pass_q <= pass_now;
        end
    end

endmodule

// File: tb/tb_mm2s_readback.sv
// Directed bench: a behavioural DataMover answers commands with an
// incrementing count, with optional data, length and status faults.
module tb_mm2s_readback;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] seed = '0;
    logic        busy, done, pass, len_err, sts_err, aresetn;
    logic [15:0] err_count;
    logic [31:0] first_err_beat;
    logic [71:0] cmd_tdata;
    logic        cmd_tvalid;
    logic        cmd_tready = 1'b0;
    logic [7:0]  sts_tdata = '0;
    logic        sts_tvalid = 1'b0;
    logic        sts_tready;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = 8'hFF;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    mm2s_readback #(
        .BASE_ADDR(32'h0000_0000),
        .BTT(23'h00_1000),
        .NUM_CMDS(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .seed(seed),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .first_err_beat(first_err_beat),
        .len_err(len_err),
        .sts_err(sts_err),
        .m_axis_mm2s_cmdsts_aresetn(aresetn),
        .S_AXIS_MM2S_CMD_tdata(cmd_tdata),
        .S_AXIS_MM2S_CMD_tvalid(cmd_tvalid),
        .S_AXIS_MM2S_CMD_tready(cmd_tready),
        .M_AXIS_MM2S_STS_tdata(sts_tdata),
        .M_AXIS_MM2S_STS_tkeep(1'b1),
        .M_AXIS_MM2S_STS_tlast(1'b1),
        .M_AXIS_MM2S_STS_tvalid(sts_tvalid),
        .M_AXIS_MM2S_STS_tready(sts_tready),
        .M_AXIS_MM2S_tdata(tdata),
        .M_AXIS_MM2S_tkeep(tkeep),
        .M_AXIS_MM2S_tlast(tlast),
        .M_AXIS_MM2S_tvalid(tvalid),
        .M_AXIS_MM2S_tready(tready)
    );

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] exp_cmd(input int c);
        logic [31:0] a;
        a = 32'(c) * 32'h1000;
        return {4'h0, 4'(c), a, 32'h4080_1000};
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_errcnt"}, err_count, 0);
        check({tag, "_first"}, first_err_beat, 32'hFFFF_FFFF);
        check({tag, "_len"}, len_err, 0);
        check({tag, "_sts"}, sts_err, 0);
        check({tag, "_cmdv"}, cmd_tvalid, 0);
        check({tag, "_rdy"}, tready, 0);
        check({tag, "_srdy"}, sts_tready, 0);
        check({tag, "_aresetn"}, aresetn, 0);
    endtask

    task automatic do_start(input logic [63:0] s);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_cmdv", cmd_tvalid, 1);
    endtask

    // Serves all four commands; per-command beat count is 512 except short_cmd.
    task automatic dm_run(input int corrupt_beat, input int short_cmd, input int bad_sts_cmd);
        int n;
        int beats;
        int gb = 0;
        for (int c = 0; c < 4; c++) begin
            n = 0;
            while (cmd_tvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) begin check("cmd_timeout", 0, 1); return; end
            check($sformatf("cmd_word%0d", c), cmd_tdata, exp_cmd(c));
            cmd_tready = 1'b1;
            @(negedge clk);
            cmd_tready = 1'b0;
            beats = (c == short_cmd) ? 511 : 512;
            for (int b = 0; b < beats; b++) begin
                n = 0;
                while (tready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
                if (n >= 50) begin check("beat_timeout", 0, 1); tvalid = 1'b0; return; end
                tdata  = 64'(gb) ^ ((gb == corrupt_beat) ? 64'd1 : 64'd0);
                tlast  = (b == beats - 1);
                tvalid = 1'b1;
                @(negedge clk);
                gb++;
            end
            tvalid = 1'b0;
            tlast  = 1'b0;
            n = 0;
            while (sts_tready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) begin check("sts_timeout", 0, 1); return; end
            sts_tdata  = (c == bad_sts_cmd) ? 8'h42 : (8'h80 | 8'(c));
            sts_tvalid = 1'b1;
            @(negedge clk);
            sts_tvalid = 1'b0;
        end
    endtask

    task automatic end_checks(input string tag, input logic ep, input logic [15:0] ee,
                              input logic [31:0] ef, input logic el, input logic es,
                              input int dc0);
        check({tag, "_done"}, done, 1);
        check({tag, "_pass"}, pass, ep);
        check({tag, "_errcnt"}, err_count, ee);
        check({tag, "_first"}, first_err_beat, ef);
        check({tag, "_len"}, len_err, el);
        check({tag, "_sts"}, sts_err, es);
        @(negedge clk);
        check({tag, "_done_once"}, done_cnt - dc0, 1);
        check({tag, "_done_low"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_pass_hold"}, pass, ep);
    endtask

    initial begin
        int dc0;
        logic [71:0] held;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_aresetn_rel", aresetn, 1);

        // Backpressure on the first command, then abort mid-transfer.
        do_start(64'd0);
        held = cmd_tdata;
        check("bp_cmd_word", cmd_tdata, exp_cmd(0));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_cmd_hold", cmd_tdata, held);
            check("bp_cmd_valid", cmd_tvalid, 1);
        end
        cmd_tready = 1'b1;
        @(negedge clk);
        cmd_tready = 1'b0;
        check("bp_xfer_rdy", tready, 1);
        for (int b = 0; b < 100; b++) begin
            tdata  = 64'(b) ^ ((b == 5) ? 64'd1 : 64'd0);
            tvalid = 1'b1;
            @(negedge clk);
        end
        tvalid = 1'b0;
        check("bp_errcnt", err_count, 1);
        check("bp_first", first_err_beat, 5);
        dc0 = done_cnt;
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_vals("abort");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - dc0, 0);
        check("abort_aresetn", aresetn, 1);

        dc0 = done_cnt;
        do_start(64'd0);
        dm_run(-1, -1, -1);
        end_checks("clean", 1, 0, 32'hFFFF_FFFF, 0, 0, dc0);

        dc0 = done_cnt;
        do_start(64'd0);
        dm_run(700, -1, -1);
        end_checks("corrupt", 0, 1, 700, 0, 0, dc0);

        dc0 = done_cnt;
        do_start(64'd0);
        dm_run(-1, 1, -1);
        end_checks("length", 0, 0, 32'hFFFF_FFFF, 1, 0, dc0);

        dc0 = done_cnt;
        do_start(64'd0);
        dm_run(-1, -1, 2);
        end_checks("status", 0, 0, 32'hFFFF_FFFF, 0, 1, dc0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
